// File: rtl/regfile_mp_scoreboard.sv
// rtl/regfile_mp_scoreboard.sv - multi-port integer register file with write bypass and busy scoreboard
module regfile_mp_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    output logic                alloc_err
);

    typedef enum logic {CLEAR, READY} state_t;

    state_t              state, state_nxt;
    logic [AW-1:0]       clr_cnt;
    logic [XLEN-1:0]     regs [NREGS];
    logic [NREGS-1:0]    busy, busy_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_cnt == AW'(NREGS - 1))
            state_nxt = READY;
    end

    always_comb begin
        ready = (state == READY);
    end

    always_ff @(posedge clk) begin
        if (rst || state != CLEAR) clr_cnt <= '0;
        else                       clr_cnt <= clr_cnt + AW'(1);
    end

    // Ascending port loop: the last nonblocking write wins, giving highest-index priority.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[clr_cnt] <= '0;
            end else begin
                for (int w = 0; w < NWR; w++) begin
                    if (wr_en[w] && wr_addr[w*AW +: AW] != '0)
                        regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    // Writes retire producers first; a same-cycle alloc re-marks the register as a new producer.
    always_comb begin
        busy_nxt = busy;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && wr_addr[w*AW +: AW] != '0)
                busy_nxt[wr_addr[w*AW +: AW]] = 1'b0;
        end
        if (alloc_en && alloc_addr != '0)
            busy_nxt[alloc_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= '0;
            alloc_err <= 1'b0;
        end else if (state == READY) begin
            busy      <= busy_nxt;
            alloc_err <= alloc_en && alloc_addr != '0 && busy[alloc_addr];
        end else begin
            alloc_err <= 1'b0;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            if (state == READY && rd_addr[p*AW +: AW] != '0) begin
                rd_data[p*XLEN +: XLEN] = regs[rd_addr[p*AW +: AW]];
                rd_busy[p]              = busy[rd_addr[p*AW +: AW]];
                if (BYPASS != 0) begin
                    for (int w = 0; w < NWR; w++) begin
                        if (wr_en[w] && wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW])
                            rd_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// tb/tb_regfile_mp_scoreboard.sv - directed table-driven bench for regfile_mp_scoreboard
module tb_regfile_mp_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  rd_addr = '0;
    logic [1:0]  wr_en = '0;
    logic [9:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        alloc_en = 1'b0;
    logic [4:0]  alloc_addr = '0;

    logic        ready_a, alloc_err_a, ready_b, alloc_err_b;
    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    regfile_mp_scoreboard #(.BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .ready(ready_a),
        .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_err(alloc_err_a)
    );

    regfile_mp_scoreboard #(.BYPASS(0)) u_dut_nb (
        .clk(clk), .rst(rst), .ready(ready_b),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_err(alloc_err_b)
    );

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        ae;
        logic [4:0]  aa;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] enb0;
        logic        eb0;
        logic        eb1;
        logic        eerr;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else             n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = '0; wr_addr = '0; wr_data = '0; alloc_en = 1'b0; alloc_addr = '0;
    endtask

    // Counts edges from a reset edge until ready rises; the sweep should take NREGS edges.
    task automatic reset_and_count(input string nm, input int pre_cycles);
        int n;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < pre_cycles; i++) step();
        if (pre_cycles > 0) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
        end
        chk({nm, "_ready_after_rst"}, {31'b0, ready_a}, 32'd0);
        chk({nm, "_err_after_rst"}, {31'b0, alloc_err_a}, 32'd0);
        n = 0;
        while (!ready_a && n < 64) begin
            #3;
            chk({nm, "_clear_rd0"}, rd_data_a[31:0], 32'd0);
            chk({nm, "_clear_busy0"}, {31'b0, rd_busy_a[0]}, 32'd0);
            step();
            n++;
        end
        idle_inputs();
        chk({nm, "_sweep_cycles"}, n, 32'd32);
        chk({nm, "_ready_b"}, {31'b0, ready_b}, 32'd1);
    endtask

    initial begin
        tbl[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,      1'b0, 5'd0,  5'd5,  5'd0, 32'hDEADBEEF, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
        tbl[1]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      1'b0, 5'd0,  5'd5,  5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{2'b11, 5'd7, 32'h11,       5'd7, 32'h22,     1'b0, 5'd0,  5'd7,  5'd5, 32'h22,       32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0};
        tbl[3]  = '{2'b01, 5'd0, 32'h55,       5'd0, 32'h0,      1'b0, 5'd0,  5'd7,  5'd0, 32'h22,       32'h0,        32'h22,       1'b0, 1'b0, 1'b0};
        tbl[4]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      1'b0, 5'd0,  5'd0,  5'd7, 32'h0,        32'h22,       32'h0,        1'b0, 1'b0, 1'b0};
        tbl[5]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      1'b1, 5'd3,  5'd3,  5'd7, 32'h0,        32'h22,       32'h0,        1'b0, 1'b0, 1'b0};
        tbl[6]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      1'b0, 5'd0,  5'd3,  5'd7, 32'h0,        32'h22,       32'h0,        1'b1, 1'b0, 1'b0};
        tbl[7]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      1'b1, 5'd3,  5'd3,  5'd0, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 1'b0};
        tbl[8]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      1'b0, 5'd0,  5'd3,  5'd0, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 1'b1};
        tbl[9]  = '{2'b10, 5'd0, 32'h0,        5'd3, 32'h33,     1'b1, 5'd3,  5'd3,  5'd0, 32'h33,       32'h0,        32'h0,        1'b1, 1'b0, 1'b0};
        tbl[10] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      1'b0, 5'd0,  5'd3,  5'd0, 32'h33,       32'h0,        32'h33,       1'b1, 1'b0, 1'b1};
        tbl[11] = '{2'b01, 5'd3, 32'h44,       5'd0, 32'h0,      1'b0, 5'd0,  5'd3,  5'd0, 32'h44,       32'h0,        32'h33,       1'b1, 1'b0, 1'b0};
        tbl[12] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      1'b0, 5'd0,  5'd3,  5'd0, 32'h44,       32'h0,        32'h44,       1'b0, 1'b0, 1'b0};
        tbl[13] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      1'b1, 5'd0,  5'd0,  5'd0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
        tbl[14] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      1'b0, 5'd0,  5'd0,  5'd3, 32'h0,        32'h44,       32'h0,        1'b0, 1'b0, 1'b0};
        tbl[15] = '{2'b11, 5'd5, 32'hAAAA,     5'd6, 32'hBBBB,   1'b1, 5'd12, 5'd6,  5'd5, 32'hBBBB,     32'hAAAA,     32'h0,        1'b0, 1'b0, 1'b0};
        tbl[16] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,      1'b0, 5'd0,  5'd12, 5'd6, 32'h0,        32'hBBBB,     32'h0,        1'b1, 1'b0, 1'b0};

        // Sweep with write/alloc attempts to x9 held throughout; all must be ignored.
        rd_addr    = {5'd0, 5'd9};
        wr_en      = 2'b11;
        wr_addr    = {5'd9, 5'd9};
        wr_data    = {32'h99999999, 32'h12345678};
        alloc_en   = 1'b1;
        alloc_addr = 5'd9;
        reset_and_count("init", 0);

        rd_addr = {5'd0, 5'd9};
        #3;
        chk("clear_x9_data", rd_data_a[31:0], 32'd0);
        chk("clear_x9_busy", {31'b0, rd_busy_a[0]}, 32'd0);
        chk("clear_alloc_err", {31'b0, alloc_err_a}, 32'd0);

        for (int r = 0; r < 32; r++) begin
            rd_addr = {5'(31 - r), 5'(r)};
            #1;
            chk($sformatf("init_zero_p0_x%0d", r), rd_data_a[31:0], 32'd0);
            chk($sformatf("init_zero_p1_x%0d", 31 - r), rd_data_a[63:32], 32'd0);
        end
        step();

        foreach (tbl[i]) begin
            wr_en      = tbl[i].we;
            wr_addr    = {tbl[i].wa1, tbl[i].wa0};
            wr_data    = {tbl[i].wd1, tbl[i].wd0};
            alloc_en   = tbl[i].ae;
            alloc_addr = tbl[i].aa;
            rd_addr    = {tbl[i].ra1, tbl[i].ra0};
            #3;
            chk($sformatf("vec%0d_rd0", i), rd_data_a[31:0], tbl[i].e0);
            chk($sformatf("vec%0d_rd1", i), rd_data_a[63:32], tbl[i].e1);
            chk($sformatf("vec%0d_nb_rd0", i), rd_data_b[31:0], tbl[i].enb0);
            chk($sformatf("vec%0d_busy0", i), {31'b0, rd_busy_a[0]}, {31'b0, tbl[i].eb0});
            chk($sformatf("vec%0d_busy1", i), {31'b0, rd_busy_a[1]}, {31'b0, tbl[i].eb1});
            chk($sformatf("vec%0d_err", i), {31'b0, alloc_err_a}, {31'b0, tbl[i].eerr});
            chk($sformatf("vec%0d_nb_err", i), {31'b0, alloc_err_b}, {31'b0, tbl[i].eerr});
            step();
        end
        idle_inputs();

        // x12 is busy here; restart the sweep at clr_cnt=10 and expect a full clear again.
        rd_addr = {5'd0, 5'd12};
        #1;
        chk("pre_rst_busy_x12", {31'b0, rd_busy_a[0]}, 32'd1);
        reset_and_count("midrst", 10);
        rd_addr = {5'd6, 5'd12};
        #1;
        chk("midrst_busy_x12", {31'b0, rd_busy_a[0]}, 32'd0);
        chk("midrst_x6_cleared", rd_data_a[63:32], 32'd0);
        chk("midrst_nb_x6_cleared", rd_data_b[63:32], 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
